// File: rtl/upuart_txarb_if.sv
// Requester/TX-FIFO side bundle of the UART TX arbiter; master = requesters + FIFO, slave = arbiter.
interface upuart_txarb_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_last;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   grant;
    logic [7:0]        fifo_data;
    logic              fifo_wr;
    logic              fifo_full;
    logic              timeout_evt;

    modport master (
        output req_valid, req_data, req_last, fifo_full,
        input  req_ready, grant, fifo_data, fifo_wr, timeout_evt
    );

    modport slave (
        input  req_valid, req_data, req_last, fifo_full,
        output req_ready, grant, fifo_data, fifo_wr, timeout_evt
    );
endinterface

// File: rtl/upuart_txarb.sv
// Round-robin message arbiter for the UART TX FIFO write port; grant one cycle after valid in IDLE.
// Zero-latency byte path: req_ready/fifo_wr follow !fifo_full combinationally, full stalls the owner.
// Build option UPUART_TXARB_TIMEOUT_EN enables revoking a lock after TIMEOUT idle cycles.
module upuart_txarb #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          nrst,
    upuart_txarb_if.slave bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    if (NREQ < 1 || NREQ > 8) begin : g_bad_nreq
        $error("upuart_txarb: NREQ must be 1..8");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("upuart_txarb: TIMEOUT must be >= 1");
    end

    typedef enum logic {IDLE, LOCK} state_t;

    state_t          state, state_nxt;
    logic [NREQ-1:0] grant_q, grant_nxt;
    logic [PW-1:0]   rr_ptr, rr_ptr_nxt;
    logic [PW-1:0]   own_idx;
    logic [PW-1:0]   sel_idx;
    logic            sel_any;
    logic            own_vld;
    logic            own_last;
    logic [7:0]      own_data;
    logic            xfer;
    logic            to_hit;

    // The owner is implied by the one-hot grant; nothing is selected while idle.
    assign own_vld  = |(bus.req_valid & grant_q);
    assign own_last = |(bus.req_last & grant_q);
    assign xfer     = (state == LOCK) && own_vld && !bus.fifo_full;

    always_comb begin
        own_idx  = '0;
        own_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_q[i]) begin
                own_idx  = PW'(i);
                own_data = bus.req_data[8*i +: 8];
            end
        end
    end

    // Walk downward so the lowest offset from rr_ptr is the last (winning) assignment.
    always_comb begin
        sel_any = 1'b0;
        sel_idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (bus.req_valid[(int'(rr_ptr) + k) % NREQ]) begin
                sel_any = 1'b1;
                sel_idx = PW'((int'(rr_ptr) + k) % NREQ);
            end
        end
    end

`ifdef UPUART_TXARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] idle_cnt, idle_cnt_nxt;
    logic          tevt_q;

    assign to_hit = (state == LOCK) && !own_vld && (idle_cnt == CW'(TIMEOUT - 1));

    // Stalled bytes (owner valid, FIFO full) hold the count: backpressure is not idleness.
    always_comb begin
        idle_cnt_nxt = idle_cnt;
        if (state == IDLE || xfer || to_hit) begin
            idle_cnt_nxt = '0;
        end else if (!own_vld) begin
            idle_cnt_nxt = idle_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            idle_cnt <= '0;
            tevt_q   <= 1'b0;
        end else begin
            idle_cnt <= idle_cnt_nxt;
            tevt_q   <= to_hit;
        end
    end

    assign bus.timeout_evt = tevt_q;
`else
    assign to_hit          = 1'b0;
    assign bus.timeout_evt = 1'b0;
`endif

    always_comb begin
        state_nxt  = state;
        grant_nxt  = grant_q;
        rr_ptr_nxt = rr_ptr;
        case (state)
            IDLE: begin
                if (sel_any) begin
                    grant_nxt = NREQ'(1) << sel_idx;
                    state_nxt = LOCK;
                end
            end
            LOCK: begin
                if ((xfer && own_last) || to_hit) begin
                    grant_nxt  = '0;
                    rr_ptr_nxt = PW'((int'(own_idx) + 1) % NREQ);
                    state_nxt  = IDLE;
                end
            end
            default: begin
                grant_nxt = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state   <= IDLE;
            grant_q <= '0;
            rr_ptr  <= '0;
        end else begin
            state   <= state_nxt;
            grant_q <= grant_nxt;
            rr_ptr  <= rr_ptr_nxt;
        end
    end

    assign bus.grant     = grant_q;
    assign bus.req_ready = bus.fifo_full ? '0 : grant_q;
    assign bus.fifo_wr   = xfer;
    assign bus.fifo_data = own_data;

    a_grant_onehot: assert property (@(posedge clk) disable iff (!nrst) $onehot0(grant_q));
    a_wr_needs_owner: assert property (@(posedge clk) disable iff (!nrst) bus.fifo_wr |-> (state == LOCK));
endmodule

// File: tb/tb_upuart_txarb.sv
// Scoreboard bench for upuart_txarb: a message-level reference model predicts per-cycle grant/ready
// and every FIFO write / timeout pulse; a negedge monitor pops and compares.
module tb_upuart_txarb;
    localparam int NREQ = 4;
    localparam int TO   = 8;

    logic clk = 1'b0;
    logic nrst;
    always #5 clk = ~clk;

    upuart_txarb_if #(.NREQ(NREQ)) bus ();
    upuart_txarb #(.NREQ(NREQ), .TIMEOUT(TO)) dut (.clk(clk), .nrst(nrst), .bus(bus));

    typedef struct {int cyc; logic [7:0] data; int src;} wr_t;
    typedef struct {logic [NREQ-1:0] grant; logic [NREQ-1:0] ready; logic [7:0] fdata;} cy_t;
    typedef logic [8:0] byte_q_t[$];

    int errs   = 0;
    int checks = 0;
    int cyc    = 0;

    wr_t     wq[$];
    cy_t     cq[$];
    int      tq[$];
    byte_q_t stream[NREQ];
    int      pause[NREQ];
    logic [NREQ-1:0] hold, acc;
    bit      rnd_mode, refill, force_full, mon_en;
    int      m_owner, m_ptr, m_idle;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic load(input int i, input int n, input logic [7:0] base);
        for (int k = 0; k < n; k++) stream[i].push_back({(k == n - 1), base + 8'(k)});
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < NREQ; i++) if (stream[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic drive();
        logic [NREQ-1:0]   v, l;
        logic [8*NREQ-1:0] d;
        v = '0; l = '0; d = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (refill && stream[i].size() == 0) load(i, $urandom_range(4, 1), 8'($urandom));
            if (stream[i].size() != 0) begin
                d[8*i +: 8] = stream[i][0][7:0];
                l[i]        = stream[i][0][8];
            end else begin
                d[8*i +: 8] = 8'($urandom);
            end
            if (rnd_mode) begin
                if (pause[i] > 0) pause[i]--;
                else if ($urandom_range(15) == 0) pause[i] = $urandom_range(12, 3);
                v[i] = (stream[i].size() != 0) && (pause[i] == 0) && ($urandom_range(3) != 0);
            end else begin
                v[i] = (stream[i].size() != 0) && !hold[i];
            end
        end
        bus.req_valid = v;
        bus.req_last  = l;
        bus.req_data  = d;
        bus.fifo_full = rnd_mode ? ($urandom_range(3) == 0) : force_full;
    endtask

    // Message-level reference: one owner at a time, served from the pointer upward.
    task automatic model();
        cy_t r;
        int  g;
        r.grant = (m_owner < 0) ? '0 : (NREQ'(1) << m_owner);
        r.ready = (m_owner >= 0 && !bus.fifo_full) ? r.grant : '0;
        r.fdata = (m_owner >= 0) ? bus.req_data[8*m_owner +: 8] : 8'h00;
        cq.push_back(r);
        if (m_owner < 0) begin
            for (int k = 0; k < NREQ; k++) begin
                if (m_owner < 0 && bus.req_valid[(m_ptr + k) % NREQ]) begin
                    m_owner = (m_ptr + k) % NREQ;
                    m_idle  = 0;
                end
            end
        end else begin
            g = m_owner;
            if (bus.req_valid[g] && !bus.fifo_full) begin
                wq.push_back('{cyc, bus.req_data[8*g +: 8], g});
                m_idle = 0;
                if (bus.req_last[g]) begin
                    m_owner = -1;
                    m_ptr   = (g + 1) % NREQ;
                end
            end else if (!bus.req_valid[g]) begin
`ifdef UPUART_TXARB_TIMEOUT_EN
                m_idle++;
                if (m_idle == TO) begin
                    m_owner = -1;
                    m_ptr   = (g + 1) % NREQ;
                    m_idle  = 0;
                    tq.push_back(cyc + 1);
                end
`endif
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < NREQ; i++) if (acc[i]) void'(stream[i].pop_front());
        drive();
        model();
        @(negedge clk);
        acc = bus.req_valid & bus.req_ready;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (n < budget && !(all_empty() && m_owner < 0)) begin
            tick();
            n++;
        end
        checks++;
        if (!(all_empty() && m_owner < 0)) begin
            errs++;
            $display("FAIL drain: traffic still pending after %0d cycles (cycle %0d)", budget, cyc);
        end
    endtask

    task automatic do_reset(input bit mid);
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) if (acc[i]) void'(stream[i].pop_front());
        acc = '0;
        if (mid) chk("grant_before_reset", int'(bus.grant), 4);
        mon_en = 1'b0;
        nrst   = 1'b0;
        #1;
        if (mid) begin
            chk("rst_mid_grant", int'(bus.grant), 0);
            chk("rst_mid_fifo_wr", int'(bus.fifo_wr), 0);
            chk("rst_mid_req_ready", int'(bus.req_ready), 0);
        end
        chk("pending_writes", wq.size(), 0);
        wq.delete(); cq.delete(); tq.delete();
        m_owner = -1; m_ptr = 0; m_idle = 0;
        bus.req_valid = '0;
        repeat (2) @(negedge clk);
        #1;
        nrst   = 1'b1;
        mon_en = 1'b1;
    endtask

    always @(negedge clk) begin : monitor
        cy_t r;
        wr_t w;
        int  t;
        if (mon_en && nrst) begin
            if (cq.size() == 0) begin
                checks++; errs++;
                $display("FAIL cycle_queue: no model entry at cycle %0d", cyc);
            end else begin
                r = cq.pop_front();
                chk("grant", int'(bus.grant), int'(r.grant));
                chk("req_ready", int'(bus.req_ready), int'(r.ready));
                chk("fifo_data", int'(bus.fifo_data), int'(r.fdata));
            end
            if (bus.fifo_wr) begin
                if (wq.size() == 0) begin
                    checks++; errs++;
                    $display("FAIL fifo_wr: unexpected write 0x%0h at cycle %0d", bus.fifo_data, cyc);
                end else begin
                    w = wq.pop_front();
                    chk("wr_cycle", cyc, w.cyc);
                    chk("wr_data", int'(bus.fifo_data), int'(w.data));
                    chk("wr_src", int'(bus.grant), 1 << w.src);
                end
            end
            if (bus.timeout_evt) begin
                if (tq.size() == 0) begin
                    checks++; errs++;
                    $display("FAIL timeout_evt: unexpected pulse at cycle %0d", cyc);
                end else begin
                    t = tq.pop_front();
                    chk("timeout_cycle", cyc, t);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        nrst = 1'b0;
        bus.req_valid = '1;
        bus.req_last  = '1;
        bus.req_data  = 32'hA5C3_5A3C;
        bus.fifo_full = 1'b0;
        rnd_mode = 0; refill = 0; force_full = 0; mon_en = 0;
        hold = '0; acc = '0;
        for (int i = 0; i < NREQ; i++) pause[i] = 0;
        m_owner = -1; m_ptr = 0; m_idle = 0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_grant", int'(bus.grant), 0);
        chk("rst_fifo_wr", int'(bus.fifo_wr), 0);
        chk("rst_fifo_data", int'(bus.fifo_data), 0);
        chk("rst_req_ready", int'(bus.req_ready), 0);
        chk("rst_timeout_evt", int'(bus.timeout_evt), 0);
        bus.req_valid = '0;
        nrst   = 1'b1;
        mon_en = 1'b1;

        // Single requester, three-byte message.
        load(1, 3, 8'h41);
        drain(50);

        // Two contenders from reset: 0 then 2, one idle cycle between.
        do_reset(1'b0);
        load(0, 2, 8'h10);
        load(2, 2, 8'h20);
        drain(50);

        // FIFO full for ten cycles in the middle of a message.
        load(3, 6, 8'h30);
        repeat (3) tick();
        force_full = 1'b1;
        repeat (10) tick();
        force_full = 1'b0;
        drain(50);

        // Owner goes quiet after one byte.
        load(2, 3, 8'h50);
        for (int n = 0; n < 20 && !acc[2]; n++) tick();
        hold[2] = 1'b1;
        repeat (3 * TO) tick();
        hold[2] = 1'b0;
        drain(80);

        // Requesters 1 and 3 streaming single-byte messages.
        for (int k = 0; k < 4; k++) begin
            load(1, 1, 8'h60 + 8'(k));
            load(3, 1, 8'h70 + 8'(k));
        end
        drain(60);

        // Reset mid-message with rr pointer away from 0, then restart from requester 0.
        load(1, 1, 8'h80);
        drain(20);
        load(2, 5, 8'h90);
        repeat (3) tick();
        do_reset(1'b1);
        load(0, 1, 8'hA0);
        drain(60);

        // Randomized traffic, valid gaps and FIFO backpressure.
        rnd_mode = 1'b1;
        refill   = 1'b1;
        repeat (3000) tick();
        refill = 1'b0;
        drain(3000);

        chk("leftover_writes", wq.size(), 0);
        chk("leftover_timeouts", tq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
